// File: rtl/inst_memory_loader.sv
// Instruction memory with a byte-serial loader: header word gives the word
// count, followed by that many instruction words; fetches are registered.
module inst_memory_loader #(
  parameter int          INST_MEM_WIDTH = 10,
  parameter logic [31:0] NOP_WORD       = 32'h08000000,
  parameter bit          LITTLE_ENDIAN  = 1'b0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  output logic [31:0]               inst,
  output logic                      distinct,
  input  logic                      loader_start,
  input  logic                      loader_valid,
  input  logic [7:0]                loader_data,
  output logic                      loading,
  output logic                      load_done,
  output logic                      load_error,
  output logic [7:0]                led
);

  localparam int          W     = INST_MEM_WIDTH;
  localparam logic [32:0] DEPTH = 33'd1 << W;
  localparam logic [W:0]  ONE   = 1;

  typedef enum logic [1:0] {
    S_IDLE, S_HDR, S_DATA, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [1:0]  r_bcnt;
  logic [W:0]  r_idx;
  logic [W:0]  r_count;
  logic [W:0]  r_loaded;
  logic [23:0] r_acc;
  logic [W-1:0] r_pc_buf;
  logic [31:0] r_inst;
  logic        r_distinct;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_led;
  logic [31:0] r_mem [0:(1<<W)-1];

  logic        w_busy;
  logic        w_take;
  logic        w_full;
  logic [31:0] w_word;
  logic [23:0] w_acc_nx;
  logic [W:0]  w_idx_inc;
  logic        w_wr;
  logic        w_commit;
  logic        w_done_nx;
  logic        w_to_data;
  logic        w_leave;
  logic [31:0] w_inst_nx;
  logic [7:0]  w_led_nx;

  assign w_busy    = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_take    = loader_valid && !loader_start && w_busy;
  assign w_full    = w_take && (r_bcnt == 2'd3);
  assign w_idx_inc = r_idx + ONE;

  // Three earlier bytes sit in r_acc; the strobed byte completes the word
  assign w_word   = LITTLE_ENDIAN ? {loader_data, r_acc}
                                  : {r_acc, loader_data};
  assign w_acc_nx = LITTLE_ENDIAN ? {loader_data, r_acc[23:8]}
                                  : {r_acc[15:0], loader_data};

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_commit   = 1'b0;
    w_done_nx  = 1'b0;
    w_to_data  = 1'b0;
    if (loader_start) begin
      w_state_nx = S_HDR;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_full) begin
            if (w_word == 32'd0) begin
              w_state_nx = S_IDLE;
              w_done_nx  = 1'b1;
            end else if ({1'b0, w_word} > DEPTH) begin
              w_state_nx = S_ERR;
            end else begin
              w_state_nx = S_DATA;
              w_to_data  = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_full) begin
            w_wr = 1'b1;
            if (w_idx_inc == r_count) begin
              w_commit   = 1'b1;
              w_done_nx  = 1'b1;
              w_state_nx = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_leave = w_busy &&
    ((w_state_nx == S_IDLE) || (w_state_nx == S_ERR));

  always_comb begin
    w_inst_nx = NOP_WORD;
    if (!w_busy && ({1'b0, pc} < r_loaded))
      w_inst_nx = r_mem[pc];
  end

  always_comb begin
    w_led_nx = w_inst_nx[31:24];
    if (w_state_nx == S_ERR)
      w_led_nx = 8'hEE;
    else if ((w_state_nx == S_HDR) || (w_state_nx == S_DATA))
      w_led_nx = w_take ? loader_data : r_led;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_loaded   <= '0;
      r_acc      <= '0;
      r_pc_buf   <= '0;
      r_inst     <= NOP_WORD;
      r_distinct <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_led      <= 8'h00;
    end else begin
      r_state    <= w_state_nx;
      r_inst     <= w_inst_nx;
      r_pc_buf   <= pc;
      r_distinct <= (pc != r_pc_buf) || w_leave;
      r_done     <= w_done_nx;
      r_led      <= w_led_nx;
      if (loader_start) begin
        r_bcnt   <= '0;
        r_idx    <= '0;
        r_count  <= '0;
        r_loaded <= '0;
        r_acc    <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_take) begin
          r_bcnt <= r_bcnt + 2'd1;
          r_acc  <= w_acc_nx;
        end
        if (w_to_data)
          r_count <= w_word[W:0];
        if (w_wr)
          r_idx <= w_idx_inc;
        if (w_commit)
          r_loaded <= r_count;
        if (w_state_nx == S_ERR && r_state == S_HDR)
          r_err <= 1'b1;
      end
    end
  end

  // Contents survive reset; r_loaded alone decides what is valid
  always_ff @(posedge CLK) begin
    if (w_wr)
      r_mem[r_idx[W-1:0]] <= w_word;
  end

  assign inst       = r_inst;
  assign distinct   = r_distinct;
  assign loading    = w_busy;
  assign load_done  = r_done;
  assign load_error = r_err;
  assign led        = r_led;

endmodule

// File: tb/tb_inst_memory_loader.sv
// Directed checks of the instruction memory loader.
// Big-endian DUT plus a little-endian DUT for byte-order check.
module tb_inst_memory_loader;

  localparam int          W   = 4;
  localparam logic [31:0] NOP = 32'h08000000;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] pc, pc2;
  logic [31:0]  inst, inst2;
  logic         distinct, distinct2;
  logic         st, vl, st2, vl2;
  logic [7:0]   dat, dat2;
  logic         loading, load_done, load_error;
  logic         loading2, load_done2, load_error2;
  logic [7:0]   led, led2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  inst_memory_loader #(.INST_MEM_WIDTH(W), .LITTLE_ENDIAN(1'b0)) u_be (
    .CLK(CLK), .reset(reset), .pc(pc), .inst(inst),
    .distinct(distinct), .loader_start(st), .loader_valid(vl),
    .loader_data(dat), .loading(loading), .load_done(load_done),
    .load_error(load_error), .led(led)
  );

  inst_memory_loader #(.INST_MEM_WIDTH(W), .LITTLE_ENDIAN(1'b1)) u_le (
    .CLK(CLK), .reset(reset), .pc(pc2), .inst(inst2),
    .distinct(distinct2), .loader_start(st2), .loader_valid(vl2),
    .loader_data(dat2), .loading(loading2), .load_done(load_done2),
    .load_error(load_error2), .led(led2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic start();
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] b);
    vl  = 1'b1;
    dat = b;
    tick();
    vl  = 1'b0;
  endtask

  task automatic sword(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) sbyte(w[i*8 +: 8]);
  endtask

  task automatic fetch(input string tag, input logic [W-1:0] a,
                       input logic [31:0] exp);
    pc = a;
    tick();
    chk(tag, inst, exp);
  endtask

  task automatic le_byte(input logic [7:0] b);
    vl2  = 1'b1;
    dat2 = b;
    tick();
    vl2  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    pc = 3; pc2 = 0;
    st = 0; vl = 0; dat = 0;
    st2 = 0; vl2 = 0; dat2 = 0;
    #12;
    chk("rst_inst", inst, NOP);
    chk("rst_distinct", {31'b0, distinct}, 1);
    chk("rst_loading", {31'b0, loading}, 0);
    chk("rst_done", {31'b0, load_done}, 0);
    chk("rst_err", {31'b0, load_error}, 0);
    chk("rst_led", {24'b0, led}, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("pc3_inst", inst, NOP);
    chk("pc3_dist1", {31'b0, distinct}, 1);
    tick();
    chk("pc3_dist0", {31'b0, distinct}, 0);
    chk("idle_led", {24'b0, led}, 32'h08);

    // Two-word load
    start();
    chk("ld_loading", {31'b0, loading}, 1);
    sword(32'd2);
    sword(32'h11223344);
    sword(32'h55667788);
    chk("ld_done1", {31'b0, load_done}, 1);
    chk("ld_leave_dist", {31'b0, distinct}, 1);
    chk("ld_loading0", {31'b0, loading}, 0);
    tick();
    chk("ld_done0", {31'b0, load_done}, 0);
    fetch("f0", 0, 32'h11223344);
    fetch("f1", 1, 32'h55667788);
    chk("f1_led", {24'b0, led}, 32'h55);
    fetch("f2", 2, NOP);

    // Oversized header
    start();
    sword(32'h00000011);
    chk("err_flag", {31'b0, load_error}, 1);
    chk("err_led", {24'b0, led}, 32'hEE);
    sbyte(8'h12);
    chk("err_ign", {31'b0, loading}, 0);
    fetch("err_f0", 0, NOP);
    fetch("err_f1", 1, NOP);
    start();
    chk("err_clr", {31'b0, load_error}, 0);
    sword(32'd0);
    chk("zero_done", {31'b0, load_done}, 1);

    // Aborted load then restart
    start();
    sword(32'd2);
    sword(32'h12345678);
    chk("mid_led", {24'b0, led}, 32'h78);
    start();
    sword(32'd1);
    sword(32'hDEADBEEF);
    chk("ab_done", {31'b0, load_done}, 1);
    fetch("ab_f0", 0, 32'hDEADBEEF);
    fetch("ab_f1", 1, NOP);

    // distinct lag
    pc = 0; tick(); tick();
    pc = 0; tick(); chk("dist_a", {31'b0, distinct}, 0);
    pc = 0; tick(); chk("dist_b", {31'b0, distinct}, 0);
    pc = 1; tick(); chk("dist_c", {31'b0, distinct}, 1);
    pc = 1; tick(); chk("dist_d", {31'b0, distinct}, 0);

    // Full-depth load
    start();
    sword(32'd16);
    for (int i = 0; i < 16; i++) sword(32'hA0000000 + i);
    chk("full_done", {31'b0, load_done}, 1);
    fetch("full_f15", 15, 32'hA000000F);
    fetch("full_f0", 0, 32'hA0000000);
    fetch("full_f9", 9, 32'hA0000009);

    // Reset during 10th word
    start();
    sword(32'd16);
    for (int i = 0; i < 9; i++) sword(32'hB0000000 + i);
    sbyte(8'hB0);
    sbyte(8'h00);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_loading", {31'b0, loading}, 0);
    chk("rst_mid_inst", inst, NOP);
    tick();
    reset = 1'b1;
    fetch("post_f0", 0, NOP);
    fetch("post_f15", 15, NOP);

    // Little-endian assembly
    st2 = 1'b1; tick(); st2 = 1'b0;
    le_byte(8'h01); le_byte(8'h00); le_byte(8'h00); le_byte(8'h00);
    le_byte(8'h44); le_byte(8'h33); le_byte(8'h22); le_byte(8'h11);
    chk("le_done", {31'b0, load_done2}, 1);
    pc2 = 0;
    tick();
    chk("le_word", inst2, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
